// File: rtl/lv_efuse_load_pkg.sv
// Shared lv parameter package: control-FSM widths, efuse geometry defaults
// and the efuse loader state encoding.
package lv_efuse_load_pkg;

  localparam int CTRL_FSM_ST_W      = 3;

  localparam int EFUSE_WORD_NUM_DEF = 8;
  localparam int EFUSE_DATA_W_DEF   = 8;
  localparam int EFUSE_ADDR_W_DEF   = 3;
  localparam int RD_WAIT_CYC_DEF    = 4;

  localparam int EFUSE_ST_W         = 2;

  typedef enum logic [EFUSE_ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } efuse_st_e;

endpackage

// File: rtl/lv_efuse_load_if.sv
// Bundle of the efuse loader's request, efuse-macro and register-file signals.
// Handshake: load_req is a level held until load_done pulses; rd_en/addr are
// presented to the macro and rdata is sampled on the last rd_en cycle of a word.
interface lv_efuse_load_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              load_req;
  logic              load_done;
  logic              vld;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    input  load_req, rdata,
    output load_done, vld, rd_en, addr, reg_wr_en, reg_addr, reg_wdata
  );

  modport slave (
    output load_req, rdata,
    input  load_done, vld, rd_en, addr, reg_wr_en, reg_addr, reg_wdata
  );
endinterface

// File: rtl/lv_efuse_load.sv
// Efuse loader: reads every efuse word, copies data words to the register file
// and validates them against the trailing XOR checksum word.
module lv_efuse_load
  import lv_efuse_load_pkg::*;
#(
  parameter int EFUSE_WORD_NUM = EFUSE_WORD_NUM_DEF,
  parameter int EFUSE_DATA_W   = EFUSE_DATA_W_DEF,
  parameter int EFUSE_ADDR_W   = EFUSE_ADDR_W_DEF,
  parameter int RD_WAIT_CYC    = RD_WAIT_CYC_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_efuse_load_req,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_vld,
  output logic                    o_efuse_rd_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
  output logic                    o_efuse_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_addr,
  output logic [EFUSE_DATA_W-1:0] o_efuse_reg_wdata,
  output efuse_st_e               o_efuse_dbg_st
);

  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
  localparam logic [3:0]              CNT_LAST = 4'(RD_WAIT_CYC - 1);

  efuse_st_e               state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [EFUSE_ADDR_W-1:0] idx_q, idx_d;
  logic [EFUSE_DATA_W-1:0] xor_q, xor_d;
  logic [EFUSE_DATA_W-1:0] chk_q, chk_d;
  logic                    nz_q, nz_d;
  logic                    last_q, last_d;
  logic                    rd_en_q, rd_en_d;
  logic [EFUSE_ADDR_W-1:0] addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [EFUSE_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [EFUSE_DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic                    done_q, done_d;
  logic                    vld_q, vld_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    chk_d       = chk_q;
    nz_d        = nz_q;
    last_d      = last_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    done_d      = 1'b0;
    vld_d       = vld_q;

    case (state_q)
      ST_IDLE: begin
        if (i_efuse_load_req) begin
          state_d = ST_RD;
          rd_en_d = 1'b1;
          addr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          xor_d   = '0;
          chk_d   = '0;
          nz_d    = 1'b0;
          last_d  = 1'b0;
          vld_d   = 1'b0;
        end
      end
      ST_RD: begin
        // rd_en low inside RD is the one-cycle gap that follows each capture.
        if (rd_en_q) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            rd_en_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              chk_d  = i_efuse_rdata;
              last_d = 1'b1;
            end else begin
              wr_en_d     = 1'b1;
              reg_addr_d  = idx_q;
              reg_wdata_d = i_efuse_rdata;
              xor_d       = xor_q ^ i_efuse_rdata;
              nz_d        = nz_q | (|i_efuse_rdata);
              idx_d       = idx_q + 1'b1;
              addr_d      = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (last_q) begin
          state_d = ST_CHK;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      ST_CHK: begin
        done_d  = 1'b1;
        vld_d   = (xor_q == chk_q) && nz_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!i_efuse_load_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      chk_q       <= '0;
      nz_q        <= 1'b0;
      last_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      chk_q       <= chk_d;
      nz_q        <= nz_d;
      last_q      <= last_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
    end
  end

  assign o_efuse_load_done = done_q;
  assign o_efuse_vld       = vld_q;
  assign o_efuse_rd_en     = rd_en_q;
  assign o_efuse_addr      = addr_q;
  assign o_efuse_reg_wr_en = wr_en_q;
  assign o_efuse_reg_addr  = reg_addr_q;
  assign o_efuse_reg_wdata = reg_wdata_q;
  assign o_efuse_dbg_st    = state_q;

endmodule

// File: tb/tb_lv_efuse_load.sv
// Bench for lv_efuse_load: directed and random loads against a word-level
// efuse model, with a queue-based scoreboard for reg writes and done/vld.
module tb_lv_efuse_load;
  import lv_efuse_load_pkg::*;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int W   = 4;
  localparam int LAT = 1 + N * (W + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lv_efuse_load_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  efuse_st_e dbg_st;

  lv_efuse_load #(
    .EFUSE_WORD_NUM(N), .EFUSE_DATA_W(DW), .EFUSE_ADDR_W(AW), .RD_WAIT_CYC(W)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_efuse_load_req (bus.load_req),
    .o_efuse_load_done(bus.load_done),
    .o_efuse_vld      (bus.vld),
    .o_efuse_rd_en    (bus.rd_en),
    .o_efuse_addr     (bus.addr),
    .i_efuse_rdata    (bus.rdata),
    .o_efuse_reg_wr_en(bus.reg_wr_en),
    .o_efuse_reg_addr (bus.reg_addr),
    .o_efuse_reg_wdata(bus.reg_wdata),
    .o_efuse_dbg_st   (dbg_st)
  );

  // Efuse macro model: word array, junk outside read strobes.
  logic [DW-1:0] fuse [N];
  always_comb bus.rdata = bus.rd_en ? fuse[bus.addr] : 8'hA5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  int               done_cyc_q[$];
  logic             done_vld_q[$];
  bit               load_active = 1'b0;
  int               rd_idx_exp  = 0;
  int               done_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic model_vld();
    logic [DW-1:0] x;
    logic          nz;
    x  = '0;
    nz = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      x  = x ^ fuse[i];
      nz = nz | (fuse[i] != 0);
    end
    return (x == fuse[N-1]) && nz;
  endfunction

  // Monitor: samples on the falling edge, pops expectations as outputs appear.
  logic prev_rd = 1'b0;
  int   run     = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      run     = 0;
    end else begin
      if (bus.reg_wr_en) begin
        if (exp_q.size() == 0) fail("unexpected_reg_wr");
        else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("reg_addr", 32'(bus.reg_addr), 32'(e[AW+DW-1:DW]));
          check("reg_wdata", 32'(bus.reg_wdata), 32'(e[DW-1:0]));
        end
        check("vld_during_load", 32'(bus.vld), 32'd0);
      end
      if (bus.load_done) begin
        if (done_cyc_q.size() == 0) fail("unexpected_done");
        else begin
          int   ec;
          logic ev;
          ec = done_cyc_q.pop_front();
          ev = done_vld_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(ec));
          check("vld_at_done", 32'(bus.vld), 32'(ev));
          check("writes_before_done", 32'(exp_q.size()), 32'd0);
        end
        load_active = 1'b0;
        done_cnt++;
      end
      if (bus.rd_en && !prev_rd) begin
        check("rd_in_load", 32'(load_active), 32'd1);
        check("rd_addr", 32'(bus.addr), 32'(rd_idx_exp));
        rd_idx_exp++;
        run = 0;
      end
      if (bus.rd_en) run++;
      if (!bus.rd_en && prev_rd) check("rd_en_len", 32'(run), 32'(W));
      prev_rd = bus.rd_en;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called only while the DUT is idle; the req is sampled on the next edge.
  task automatic start_load();
    for (int i = 0; i < N - 1; i++) exp_q.push_back({AW'(i), fuse[i]});
    done_cyc_q.push_back(cyc + 1 + LAT);
    done_vld_q.push_back(model_vld());
    rd_idx_exp   = 0;
    load_active  = 1'b1;
    bus.load_req = 1'b1;
    wait_cycles(1);
    check("vld_clear_on_start", 32'(bus.vld), 32'd0);
  endtask

  task automatic wait_done(input int start_cnt);
    for (int k = 0; k < 200 && done_cnt == start_cnt; k++) wait_cycles(1);
    if (done_cnt == start_cnt) fail("done_timeout");
  endtask

  task automatic run_load(input int drop_at, input int hold_after);
    int   c0;
    logic ev;
    c0 = done_cnt;
    ev = model_vld();
    start_load();
    if (drop_at > 1) begin
      wait_cycles(drop_at - 1);
      bus.load_req = 1'b0;
    end
    wait_done(c0);
    if (hold_after > 0) wait_cycles(hold_after);
    check("single_done", 32'(done_cnt - c0), 32'd1);
    check("rd_words", 32'(rd_idx_exp), 32'(N));
    check("vld_level", 32'(bus.vld), 32'(ev));
    bus.load_req = 1'b0;
    wait_cycles(2);
  endtask

  task automatic set_fuse(input logic [8*DW-1:0] w);
    for (int i = 0; i < N; i++) fuse[i] = w[(N-1-i)*DW +: DW];
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, 32'(bus.load_done), 32'd0);
    check({tag, "_vld"}, 32'(bus.vld), 32'd0);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_reg_wr_en"}, 32'(bus.reg_wr_en), 32'd0);
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
    check({tag, "_state"}, 32'(dbg_st), 32'(ST_IDLE));
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.load_req = 1'b0;
    for (int i = 0; i < N; i++) fuse[i] = '0;
    wait_cycles(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    wait_cycles(3);
    check("idle_no_rd", 32'(bus.rd_en), 32'd0);

    // Good load, bad checksum, blank efuse.
    set_fuse(64'h11_22_44_08_00_00_00_7F);
    run_load(0, 3);
    set_fuse(64'h11_22_44_08_00_00_00_7E);
    run_load(0, 3);
    set_fuse(64'h0);
    run_load(0, 3);

    // Req dropped at cycle 10, then a fresh request.
    set_fuse(64'h11_22_44_08_00_00_00_7F);
    run_load(10, 5);
    set_fuse(64'h01_02_03_04_05_06_07_08);
    run_load(0, 2);

    // Reset mid-load aborts without a done pulse; next load starts at addr 0.
    begin
      int c0;
      set_fuse(64'h11_22_44_08_00_00_00_7F);
      c0 = done_cnt;
      start_load();
      wait_cycles(19);
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_reset");
      exp_q.delete();
      done_cyc_q.delete();
      done_vld_q.delete();
      load_active  = 1'b0;
      bus.load_req = 1'b0;
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(3);
      check("abort_no_done", 32'(done_cnt - c0), 32'd0);
      check("post_reset_idle", 32'(bus.rd_en), 32'd0);
      run_load(0, 2);
    end

    // Req held long after done: one done, no extra reads.
    set_fuse(64'h11_22_44_08_00_00_00_7F);
    run_load(0, 50);

    // Random loads; half of them carry a correct checksum.
    for (int t = 0; t < 20; t++) begin
      logic [DW-1:0] x;
      x = '0;
      for (int i = 0; i < N - 1; i++) begin
        fuse[i] = DW'($urandom_range(0, 255));
        x       = x ^ fuse[i];
      end
      fuse[N-1] = ($urandom_range(0, 1) != 0) ? x : DW'($urandom_range(0, 255));
      run_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 35)) : 0,
               int'($urandom_range(0, 5)));
    end

    wait_cycles(5);
    check("leftover_writes", 32'(exp_q.size()), 32'd0);
    check("leftover_dones", 32'(done_cyc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
